// File: rtl/mac_wr_frontend.sv
`default_nettype none
// ============================================================================
// Module : mac_wr_frontend
// Store-and-forward write-request responder. Buffers one burst, checks its
// length and replays good bursts beat-by-beat to the MAC write scheduler.
// Rev    : 1.0
// ============================================================================
module mac_wr_frontend #(
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned ADDR_STEP = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iMAC_ValidWr,
  input  logic [31:0] iMAC_AddrWr,
  input  logic [3:0]  iMAC_TagWr,
  input  logic [2:0]  iMAC_IdWr,
  input  logic [1:0]  iMAC_LenWr,
  input  logic [3:0]  iMAC_QoSWr,
  output logic        oMAC_ReadyWr,
  input  logic [31:0] iMAC_DataWr,
  input  logic [3:0]  iMAC_MaskWr,
  input  logic        iMAC_EoD,
  output logic        oWB_Valid,
  input  logic        iWB_Ready,
  output logic [31:0] oWB_Addr,
  output logic [31:0] oWB_Data,
  output logic [3:0]  oWB_Mask,
  output logic [3:0]  oWB_Tag,
  output logic [2:0]  oWB_Id,
  output logic [3:0]  oWB_QoS,
  output logic        oWB_Last,
  output logic        oWrDone,
  output logic [3:0]  oWrDoneTag,
  output logic [1:0]  oWrStatus,
  output logic        oReqDrop
);

  localparam int unsigned       c_TW      = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0]   c_TMR_MAX = c_TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_addr;
  logic [3:0]       r_tag;
  logic [2:0]       r_id;
  logic [3:0]       r_qos;
  logic [2:0]       r_exp;
  logic [2:0]       r_cnt;
  logic             r_ovf;
  logic [1:0]       r_rd;
  logic [c_TW-1:0]  r_timer;
  logic [1:0]       r_status;
  logic             r_drop;
  logic [31:0]      r_buf_data [4];
  logic [3:0]       r_buf_mask [4];

  logic             w_beat, w_store, w_ovf_now, w_eod, w_len_ok, w_tmo;
  logic             w_flush, w_last, w_drain;
  logic [2:0]       w_cnt_nxt;

  assign w_beat    = (r_state == S_DATA) && ((|iMAC_MaskWr) || iMAC_EoD);
  assign w_store   = w_beat && (|iMAC_MaskWr) && (r_cnt < r_exp);
  assign w_ovf_now = w_beat && (|iMAC_MaskWr) && (r_cnt >= r_exp);
  assign w_cnt_nxt = r_cnt + {2'b00, w_store};
  assign w_eod     = w_beat && iMAC_EoD;
  assign w_len_ok  = (w_cnt_nxt == r_exp) && !(r_ovf || w_ovf_now);
  // EoD on the final allowed cycle still wins over the timeout
  assign w_tmo     = (r_state == S_DATA) && !w_eod && (r_timer == c_TMR_MAX);
  assign w_flush   = (w_eod && !w_len_ok) || w_tmo;
  assign w_drain   = (r_state == S_DRAIN);
  assign w_last    = ({1'b0, r_rd} == (r_exp - 3'd1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (iMAC_ValidWr) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_eod)      w_state_nxt = w_len_ok ? S_DRAIN : S_DONE;
        else if (w_tmo) w_state_nxt = S_DONE;
      end
      S_DRAIN: if (iWB_Ready && w_last) w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr   <= '0;
      r_tag    <= '0;
      r_id     <= '0;
      r_qos    <= '0;
      r_exp    <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
      r_rd     <= '0;
      r_timer  <= '0;
      r_status <= '0;
      r_drop   <= 1'b0;
    end else begin
      r_drop <= iMAC_ValidWr && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: if (iMAC_ValidWr) begin
          r_addr  <= iMAC_AddrWr;
          r_tag   <= iMAC_TagWr;
          r_id    <= iMAC_IdWr;
          r_qos   <= iMAC_QoSWr;
          r_exp   <= (iMAC_LenWr == 2'b11) ? 3'd4 : (iMAC_LenWr == 2'b10) ? 3'd2 : 3'd1;
          r_cnt   <= '0;
          r_ovf   <= 1'b0;
          r_rd    <= '0;
          r_timer <= '0;
        end
        S_DATA: begin
          r_cnt   <= w_cnt_nxt;
          r_ovf   <= r_ovf | w_ovf_now;
          r_timer <= r_timer + 1'b1;
          if (w_eod && !w_len_ok) r_status <= 2'b01;
          else if (w_tmo)         r_status <= 2'b10;
        end
        S_DRAIN: if (iWB_Ready) begin
          r_rd <= r_rd + 2'd1;
          if (w_last) r_status <= 2'b00;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 4; i++) begin
        r_buf_data[i] <= '0;
        r_buf_mask[i] <= '0;
      end
    end else if (w_flush) begin
      for (int i = 0; i < 4; i++) begin
        r_buf_data[i] <= '0;
        r_buf_mask[i] <= '0;
      end
    end else if (w_store) begin
      r_buf_data[r_cnt[1:0]] <= iMAC_DataWr;
      r_buf_mask[r_cnt[1:0]] <= iMAC_MaskWr;
    end
  end

  assign oMAC_ReadyWr = (r_state == S_DATA);
  assign oWB_Valid    = w_drain;
  assign oWB_Addr     = w_drain ? (r_addr + (32'(r_rd) * 32'(ADDR_STEP))) : '0;
  assign oWB_Data     = w_drain ? r_buf_data[r_rd] : '0;
  assign oWB_Mask     = w_drain ? r_buf_mask[r_rd] : '0;
  assign oWB_Tag      = w_drain ? r_tag : '0;
  assign oWB_Id       = w_drain ? r_id  : '0;
  assign oWB_QoS      = w_drain ? r_qos : '0;
  assign oWB_Last     = w_drain && w_last;
  assign oWrDone      = (r_state == S_DONE);
  assign oWrDoneTag   = (r_state == S_DONE) ? r_tag : '0;
  assign oWrStatus    = r_status;
  assign oReqDrop     = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_mac_wr_frontend.sv
`default_nettype none
// ============================================================================
// Module : tb_mac_wr_frontend
// Randomized bench for mac_wr_frontend with a burst-level scoreboard model.
// Rev    : 1.0
// ============================================================================
module tb_mac_wr_frontend;

  localparam int TIMEOUT = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [3:0]  tag;
    logic [2:0]  id;
    logic [3:0]  qos;
    logic        last;
  } beat_t;

  logic        clk, resetn;
  logic        iMAC_ValidWr, iMAC_EoD, iWB_Ready;
  logic [31:0] iMAC_AddrWr, iMAC_DataWr;
  logic [3:0]  iMAC_TagWr, iMAC_QoSWr, iMAC_MaskWr;
  logic [2:0]  iMAC_IdWr;
  logic [1:0]  iMAC_LenWr;
  logic        oMAC_ReadyWr, oWB_Valid, oWB_Last, oWrDone, oReqDrop;
  logic [31:0] oWB_Addr, oWB_Data;
  logic [3:0]  oWB_Mask, oWB_Tag, oWB_QoS, oWrDoneTag;
  logic [2:0]  oWB_Id;
  logic [1:0]  oWrStatus;

  mac_wr_frontend #(.TIMEOUT(TIMEOUT), .ADDR_STEP(4)) dut (
    .clk(clk), .resetn(resetn),
    .iMAC_ValidWr(iMAC_ValidWr), .iMAC_AddrWr(iMAC_AddrWr), .iMAC_TagWr(iMAC_TagWr),
    .iMAC_IdWr(iMAC_IdWr), .iMAC_LenWr(iMAC_LenWr), .iMAC_QoSWr(iMAC_QoSWr),
    .oMAC_ReadyWr(oMAC_ReadyWr), .iMAC_DataWr(iMAC_DataWr), .iMAC_MaskWr(iMAC_MaskWr),
    .iMAC_EoD(iMAC_EoD), .oWB_Valid(oWB_Valid), .iWB_Ready(iWB_Ready),
    .oWB_Addr(oWB_Addr), .oWB_Data(oWB_Data), .oWB_Mask(oWB_Mask), .oWB_Tag(oWB_Tag),
    .oWB_Id(oWB_Id), .oWB_QoS(oWB_QoS), .oWB_Last(oWB_Last), .oWrDone(oWrDone),
    .oWrDoneTag(oWrDoneTag), .oWrStatus(oWrStatus), .oReqDrop(oReqDrop)
  );

  int          total = 0, bad = 0;
  int          cyc = 0, last_hs_cyc = 0, drop_seen = 0, drop_exp = 0, hold_cnt = 0;
  bit          rdy_rand = 1'b0;
  beat_t       exp_q[$];
  logic [5:0]  done_q[$];
  beat_t       hs_log[$];
  logic [5:0]  done_log[$];
  logic [31:0] bd [8];
  logic [3:0]  bm [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic fail(input string nm);
    total++;
    bad++;
    $display("FAIL %s (event not allowed here)", nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Downstream ready: optional forced-low window, then always-1 or random
  initial begin
    iWB_Ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (hold_cnt > 0) begin
        iWB_Ready = 1'b0;
        hold_cnt--;
      end else begin
        iWB_Ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Scoreboard: compare every cycle against queued burst-level expectations
  always @(negedge clk) begin
    beat_t d, e;
    cyc = cyc + 1;
    if (resetn) begin
      if (oReqDrop) drop_seen++;
      if (oWB_Valid) begin
        d.addr = oWB_Addr; d.data = oWB_Data; d.mask = oWB_Mask; d.tag = oWB_Tag;
        d.id = oWB_Id; d.qos = oWB_QoS; d.last = oWB_Last;
        if (exp_q.size() == 0) fail("unexpected_wb_valid");
        else begin
          e = exp_q[0];
          chk("wb_addr", d.addr, e.addr);
          chk("wb_data", d.data, e.data);
          chk("wb_mask", 32'(d.mask), 32'(e.mask));
          chk("wb_tag",  32'(d.tag),  32'(e.tag));
          chk("wb_id",   32'(d.id),   32'(e.id));
          chk("wb_qos",  32'(d.qos),  32'(e.qos));
          chk("wb_last", 32'(d.last), 32'(e.last));
          if (iWB_Ready) begin
            void'(exp_q.pop_front());
            hs_log.push_back(d);
            if (e.last) last_hs_cyc = cyc;
          end
        end
      end
      if (oWrDone) begin
        done_log.push_back({oWrDoneTag, oWrStatus});
        if (done_q.size() == 0) fail("unexpected_wrdone");
        else begin
          chk("done_tag",    32'(oWrDoneTag), 32'(done_q[0][5:2]));
          chk("done_status", 32'(oWrStatus),  32'(done_q[0][1:0]));
          if (done_q[0][1:0] == 2'b00) chk("last_to_done_lat", 32'(cyc - last_hs_cyc), 32'd1);
          void'(done_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (done_q.size() != 0 && n < 400) begin
      tick();
      n++;
    end
    if (done_q.size() != 0) begin
      fail("done_timeout");
      done_q.delete();
      exp_q.delete();
    end
    chk("beats_left", 32'(exp_q.size()), 32'd0);
    chk("drop_count", 32'(drop_seen), 32'(drop_exp));
  endtask

  task automatic send_req(input logic [31:0] a, input logic [3:0] tg, input logic [2:0] id,
                          input logic [1:0] ln, input logic [3:0] q);
    chk("idle_ready_low", 32'(oMAC_ReadyWr), 32'd0);
    iMAC_ValidWr = 1'b1; iMAC_AddrWr = a; iMAC_TagWr = tg;
    iMAC_IdWr = id; iMAC_LenWr = ln; iMAC_QoSWr = q;
    tick();
    iMAC_ValidWr = 1'b0; iMAC_AddrWr = $urandom; iMAC_TagWr = 4'($urandom);
    chk("req_to_ready_lat", 32'(oMAC_ReadyWr), 32'd1);
  endtask

  // Model: expected beats come straight from the length code and beat count
  task automatic run_burst(input logic [31:0] a, input logic [3:0] tg, input logic [2:0] id,
                           input logic [1:0] ln, input logic [3:0] q, input int nb,
                           input bit eod_alone, input int gap, input bit xreq,
                           input bit dreq, input int hold);
    int    e;
    bit    good;
    beat_t b;
    e    = (ln == 2'b11) ? 4 : (ln == 2'b10) ? 2 : 1;
    good = (nb == e);
    if (good) begin
      for (int k = 0; k < e; k++) begin
        b.addr = a + 32'(k) * 32'd4; b.data = bd[k]; b.mask = bm[k];
        b.tag = tg; b.id = id; b.qos = q; b.last = (k == e - 1);
        exp_q.push_back(b);
      end
      done_q.push_back({tg, 2'b00});
    end else begin
      done_q.push_back({tg, 2'b01});
    end
    send_req(a, tg, id, ln, q);
    for (int k = 0; k < nb; k++) begin
      repeat ($urandom_range(0, gap)) tick();
      iMAC_DataWr = bd[k]; iMAC_MaskWr = bm[k];
      iMAC_EoD = !eod_alone && (k == nb - 1);
      if (xreq && k == 0) begin
        iMAC_ValidWr = 1'b1;
        drop_exp++;
      end
      if (iMAC_EoD) hold_cnt = hold;
      tick();
      iMAC_ValidWr = 1'b0; iMAC_MaskWr = '0; iMAC_EoD = 1'b0; iMAC_DataWr = $urandom;
    end
    if (eod_alone) begin
      repeat ($urandom_range(0, gap)) tick();
      iMAC_EoD = 1'b1; iMAC_MaskWr = '0; hold_cnt = hold;
      tick();
      iMAC_EoD = 1'b0;
    end
    chk("eod_ready_drop", 32'(oMAC_ReadyWr), 32'd0);
    chk("eod_to_valid_lat", 32'(oWB_Valid), 32'(good));
    if (!good) chk("bad_done_lat", 32'(oWrDone), 32'd1);
    if (dreq && good) begin
      iMAC_ValidWr = 1'b1;
      drop_exp++;
      tick();
      iMAC_ValidWr = 1'b0;
    end
    wait_idle();
  endtask

  task automatic scen1();
    hs_log.delete(); done_log.delete();
    bd[0] = 32'hABCD_EF12; bm[0] = 4'b1101;
    bd[1] = 32'hCBCD_EF12; bm[1] = 4'b1011;
    run_burst(32'h2345_F220, 4'd0, 3'd5, 2'b10, 4'd6, 2, 1'b0, 0, 1'b0, 1'b0, 0);
    if (hs_log.size() == 2) begin
      chk("s1_addr0", hs_log[0].addr, 32'h2345_F220);
      chk("s1_addr1", hs_log[1].addr, 32'h2345_F224);
      chk("s1_mask0", 32'(hs_log[0].mask), 32'hD);
      chk("s1_mask1", 32'(hs_log[1].mask), 32'hB);
      chk("s1_last1", 32'(hs_log[1].last), 32'd1);
      chk("s1_id_qos", 32'({hs_log[0].id, hs_log[0].qos}), 32'({3'd5, 4'd6}));
    end else chk("s1_beats", 32'(hs_log.size()), 32'd2);
    if (done_log.size() == 1) chk("s1_done", 32'(done_log[0]), 32'h00);
    else chk("s1_done_count", 32'(done_log.size()), 32'd1);
  endtask

  initial begin
    resetn = 1'b0; iMAC_ValidWr = 1'b0; iMAC_AddrWr = '0; iMAC_TagWr = '0;
    iMAC_IdWr = '0; iMAC_LenWr = '0; iMAC_QoSWr = '0; iMAC_DataWr = '0;
    iMAC_MaskWr = '0; iMAC_EoD = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outputs_zero", 32'(|{oMAC_ReadyWr, oWB_Valid, oWB_Addr, oWB_Data, oWB_Mask, oWB_Last,
                                  oWrDone, oWrDoneTag, oWrStatus, oReqDrop}), 32'd0);
    resetn = 1'b1;
    tick();

    // Directed: two-beat burst
    scen1();

    // Directed: four beats wrapping the address space, ready held low
    hs_log.delete(); done_log.delete();
    for (int k = 0; k < 4; k++) begin
      bd[k] = 32'h1000_0000 + 32'(k); bm[k] = 4'hF;
    end
    run_burst(32'hFFFF_FFF8, 4'd3, 3'd1, 2'b11, 4'd2, 4, 1'b0, 0, 1'b0, 1'b0, 10);
    if (hs_log.size() == 4) begin
      chk("s2_addr0", hs_log[0].addr, 32'hFFFF_FFF8);
      chk("s2_addr1", hs_log[1].addr, 32'hFFFF_FFFC);
      chk("s2_addr2", hs_log[2].addr, 32'h0000_0000);
      chk("s2_addr3", hs_log[3].addr, 32'h0000_0004);
    end else chk("s2_beats", 32'(hs_log.size()), 32'd4);

    // Directed: too few beats for len=10
    hs_log.delete(); done_log.delete();
    bd[0] = 32'h5555_AAAA; bm[0] = 4'h1;
    run_burst(32'h0000_1000, 4'd7, 3'd2, 2'b10, 4'd1, 1, 1'b0, 0, 1'b0, 1'b0, 0);
    chk("s3_no_beats", 32'(hs_log.size()), 32'd0);
    if (done_log.size() == 1) chk("s3_done", 32'(done_log[0]), 32'({4'd7, 2'b01}));
    else chk("s3_done_count", 32'(done_log.size()), 32'd1);

    // Directed: no beats at all -> timeout
    begin
      int n = 1;
      done_q.push_back({4'd9, 2'b10});
      send_req(32'h0000_2000, 4'd9, 3'd0, 2'b00, 4'd0);
      while (oMAC_ReadyWr && n < 200) begin
        tick();
        if (oMAC_ReadyWr) n++;
      end
      chk("timeout_ready_cycles", 32'(n), 32'(TIMEOUT));
      chk("timeout_done_now", 32'(oWrDone), 32'd1);
      wait_idle();
    end

    // Directed: reset mid-DATA after one beat
    send_req(32'h0000_3000, 4'd4, 3'd4, 2'b11, 4'd4);
    iMAC_DataWr = 32'hDEAD_BEEF; iMAC_MaskWr = 4'hF;
    tick();
    iMAC_MaskWr = '0;
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_outputs_zero", 32'(|{oMAC_ReadyWr, oWB_Valid, oWB_Addr, oWB_Data, oWB_Mask, oWB_Last,
                                        oWrDone, oWrDoneTag, oReqDrop}), 32'd0);
    chk("async_rst_status_zero", 32'(oWrStatus), 32'd0);
    exp_q.delete(); done_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    tick();
    scen1();

    // Directed: request during DRAIN is dropped; next request accepted
    for (int k = 0; k < 2; k++) begin
      bd[k] = $urandom; bm[k] = 4'($urandom_range(1, 15));
    end
    run_burst(32'h0000_4000, 4'd5, 3'd3, 2'b10, 4'd8, 2, 1'b0, 0, 1'b0, 1'b1, 3);
    for (int k = 0; k < 1; k++) begin
      bd[k] = $urandom; bm[k] = 4'($urandom_range(1, 15));
    end
    run_burst(32'h0000_5000, 4'd6, 3'd6, 2'b01, 4'd9, 1, 1'b0, 0, 1'b0, 1'b0, 0);

    // Randomized bursts
    rdy_rand = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [1:0]  ln;
      logic [31:0] a;
      int          nb, e;
      bit          ea;
      ln = 2'($urandom);
      e  = (ln == 2'b11) ? 4 : (ln == 2'b10) ? 2 : 1;
      nb = ($urandom_range(0, 1) == 1) ? e : int'($urandom_range(0, 5));
      ea = (nb == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 3)) * 32'd4)
                                       : ($urandom & 32'hFFFF_FFFC);
      for (int k = 0; k < 8; k++) begin
        bd[k] = $urandom;
        bm[k] = 4'($urandom_range(1, 15));
      end
      run_burst(a, 4'($urandom), 3'($urandom), ln, 4'($urandom), nb, ea, 2,
                ($urandom_range(0, 3) == 0), 1'b0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mac_wr_frontend.md
Name: mac_wr_frontend

Overview:
- Host-side responder for the MAC write-request channel. Accepts one write request (addr/tag/id/len/qos) and its data beats (data/mask/EoD) from an initiator.
- Buffers the burst store-and-forward and checks its length, then forwards good bursts beat-by-beat to the MAC write scheduler over a valid/ready port.
- Reports completion status per tag.

Parameters:
- TIMEOUT, 64, max cycles in DATA without EoD before the burst is aborted (≥4)
- ADDR_STEP, 4, byte address increment per forwarded beat

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous active-low reset
- iMAC_ValidWr  in  1  write request, single-cycle pulse, no request-side ready
- iMAC_AddrWr  in  32  burst base byte address
- iMAC_TagWr  in  4  transaction tag
- iMAC_IdWr  in  3  initiator id
- iMAC_LenWr  in  2  burst length code: 00=1 beat, 01=1 beat, 10=2 beats, 11=4 beats
- iMAC_QoSWr  in  4  priority
- oMAC_ReadyWr  out  1  data phase open; beats accepted while high
- iMAC_DataWr  in  32  write data beat
- iMAC_MaskWr  in  4  byte enables; nonzero marks a valid beat
- iMAC_EoD  in  1  last beat of burst
- oWB_Valid  out  1  downstream beat valid
- iWB_Ready  in  1  downstream accept
- oWB_Addr  out  32  beat address
- oWB_Data  out  32  beat data
- oWB_Mask  out  4  beat byte enables
- oWB_Tag / oWB_Id / oWB_QoS  out  4/3/4  request attributes
- oWB_Last  out  1  final beat of burst
- oWrDone  out  1  one-cycle completion pulse
- oWrDoneTag  out  4  tag of completed burst
- oWrStatus  out  2  00 OK, 01 length mismatch, 10 timeout
- oReqDrop  out  1  one-cycle pulse: request arrived while busy

Behaviour:
- Reset (async, any time):
  - state IDLE; 4-entry beat buffer flushed; beat counter and timer cleared.
  - All outputs 0. No oWrDone is issued for an interrupted burst.
- IDLE:
  - oMAC_ReadyWr=0.
  - iMAC_ValidWr=1 at edge T: latch addr/tag/id/len/qos, expected count E from len. Go to DATA; oMAC_ReadyWr=1 from T+1.
- DATA:
  - A beat qualifies on an edge where oMAC_ReadyWr=1 and (|iMAC_MaskWr or iMAC_EoD).
  - A beat with mask≠0 is written into the buffer and increments count N. EoD with mask=0 terminates the burst without writing data.
  - Beats beyond E (before EoD) are not stored; they force a mismatch.
  - On the EoD edge: oMAC_ReadyWr drops next cycle.
    - If N==E and no overflow: go to DRAIN.
    - Otherwise: flush buffer, go to DONE with status 01.
  - The timer counts DATA cycles from 0. When it reaches TIMEOUT without EoD: flush, go to DONE with status 10.
- DRAIN:
  - oWB_Valid=1 with the head beat. oWB_Addr = base + k*ADDR_STEP, modulo 2^32 (0xFFFF_FFFC+4 wraps to 0).
  - oWB_Last=1 on beat k=E-1.
  - Outputs hold stable while iWB_Ready=0. Advance on the Valid&&Ready edge.
  - After the Last handshake: go to DONE with status 00.
- DONE (1 cycle):
  - oWrDone=1, oWrDoneTag=latched tag, oWrStatus set. Then go to IDLE.
  - oWrStatus holds its value until the next oWrDone.
- Request while not IDLE (DATA/DRAIN/DONE): ignored, oReqDrop=1 the next cycle; the current burst is unaffected. A request in the DONE cycle is also dropped.
- Latency:
  - Request to oMAC_ReadyWr: 1 cycle.
  - EoD edge to first oWB_Valid: 1 cycle.
  - Last handshake to oWrDone: 1 cycle.
- A mismatched or timed-out burst never produces oWB_Valid.

Test Plan:
- ValidWr addr=0x2345_F220 tag=0 id=5 len=10 qos=6; beats 0xABCD_EF12/1101, then 0xCBCD_EF12/1011+EoD; iWB_Ready=1 -> two beats at 0x2345_F220 and 0x2345_F224, masks 1101/1011, Last on second, id=5 qos=6; oWrDone tag 0 status 00.
- len=11, addr=0xFFFF_FFF8, 4 beats; iWB_Ready low for 10 cycles -> Valid/Data held stable; addresses FFF8, FFFC, 0000_0000, 0000_0004; done status 00 one cycle after 4th handshake.
- len=10, single beat with EoD -> no oWB_Valid; oWrDone status 01; ReadyWr low the cycle after EoD.
- len=00, no beats -> at TIMEOUT (64) cycles ReadyWr drops, oWrDone status 10, no oWB_Valid.
- Second ValidWr during DRAIN -> oReqDrop pulse; first burst completes intact; the next request after IDLE is accepted.
- resetn low in DATA after one beat -> all outputs 0 asynchronously, no oWrDone; a following burst per scenario 1 passes.
